// File: rtl/charlieplex_pwm_display.sv
// rtl/charlieplex_pwm_display.sv - charlieplexed LED driver with per-pixel PWM, dead time and frame snapshot
// Optional CHARLIEPLEX_SKIP_DARK_EN: zero-brightness pixels collapse to a 1-cycle slot.
package charlieplex_pwm_display_pkg;
  function automatic int pins_for(input int pixels);
    int n;
    n = 2;
    while (n * (n - 1) < pixels) n++;
    return n;
  endfunction
endpackage

module charlieplex_pwm_display
  import charlieplex_pwm_display_pkg::*;
#(
  parameter int PIXELCOUNT     = 12,
  parameter int BRIGHTNESSBITS = 4,
  parameter int BLANKCYCLES    = 1,
  parameter int PRESCALE       = 1,
  localparam int PINCOUNT      = pins_for(PIXELCOUNT)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               enable,
  input  logic [PIXELCOUNT*BRIGHTNESSBITS-1:0] pixel_data,
  output logic [PINCOUNT-1:0]                out_en,
  output logic [PINCOUNT-1:0]                out_value,
  output logic                               frame_start
);

  localparam int B    = BRIGHTNESSBITS;
  localparam int SLOT = BLANKCYCLES + ((1 << B) - 1) * PRESCALE;
  localparam int IW   = $clog2(PIXELCOUNT);
  localparam int SW   = $clog2(SLOT);
  localparam int PW   = $clog2(PRESCALE + 1);

  typedef enum logic [1:0] {S_LOAD, S_BLANK, S_ON} state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_index;
  logic [SW-1:0]           r_slot_cnt;
  logic [PW-1:0]           r_pre_cnt;
  logic [B-1:0]            r_tick;
  logic [PIXELCOUNT*B-1:0] r_snap;

  logic [B-1:0]            w_bright;
  logic                    w_last;
  logic                    w_skip;
  logic [PINCOUNT-1:0]     w_pin_en;
  logic [PINCOUNT-1:0]     w_pin_val;
  int                      w_x;
  int                      w_r;
  int                      w_y;

  // Anode x and cathode y derive from the pixel index; y skips over x.
  always_comb begin
    w_bright  = B'(r_snap >> (int'(r_index) * B));
    w_x       = int'(r_index) / (PINCOUNT - 1);
    w_r       = int'(r_index) % (PINCOUNT - 1);
    w_y       = (w_r < w_x) ? w_r : w_r + 1;
    w_pin_val = PINCOUNT'(1) << w_x;
    w_pin_en  = w_pin_val | (PINCOUNT'(1) << w_y);
  end

  assign w_last = (r_index == IW'(PIXELCOUNT - 1));

`ifdef CHARLIEPLEX_SKIP_DARK_EN
  assign w_skip = (w_bright == '0);
`else
  assign w_skip = 1'b0;
`endif

  // Outputs are registered from the current state, so they trail the FSM by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_LOAD;
      r_index     <= '0;
      r_slot_cnt  <= '0;
      r_pre_cnt   <= '0;
      r_tick      <= '0;
      r_snap      <= '0;
      out_en      <= '0;
      out_value   <= '0;
      frame_start <= 1'b0;
    end else begin
      out_en      <= '0;
      out_value   <= '0;
      frame_start <= 1'b0;
      case (r_state)
        S_LOAD: begin
          r_snap      <= pixel_data;
          frame_start <= 1'b1;
          r_index     <= '0;
          r_slot_cnt  <= '0;
          r_state     <= S_BLANK;
        end
        S_BLANK: begin
          if (w_skip) begin
            r_slot_cnt <= '0;
            if (w_last) r_state <= S_LOAD;
            else        r_index <= r_index + IW'(1);
          end else begin
            r_slot_cnt <= r_slot_cnt + SW'(1);
            if (r_slot_cnt == SW'(BLANKCYCLES - 1)) begin
              r_state   <= S_ON;
              r_pre_cnt <= '0;
              r_tick    <= '0;
            end
          end
        end
        S_ON: begin
          if (enable && (r_tick < w_bright)) begin
            out_en    <= w_pin_en;
            out_value <= w_pin_val;
          end
          if (r_pre_cnt == PW'(PRESCALE - 1)) begin
            r_pre_cnt <= '0;
            r_tick    <= r_tick + B'(1);
          end else begin
            r_pre_cnt <= r_pre_cnt + PW'(1);
          end
          if (r_slot_cnt == SW'(SLOT - 1)) begin
            r_slot_cnt <= '0;
            if (w_last) begin
              r_state <= S_LOAD;
            end else begin
              r_index <= r_index + IW'(1);
              r_state <= S_BLANK;
            end
          end else begin
            r_slot_cnt <= r_slot_cnt + SW'(1);
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_charlieplex_pwm_display.sv
// tb/tb_charlieplex_pwm_display.sv - directed bench for charlieplex_pwm_display (6 pixels, B=2, blank 1, prescale 2)
module tb_charlieplex_pwm_display;

  localparam int FRAME = 43;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [11:0] pixel_data = '0;
  logic [2:0]  out_en;
  logic [2:0]  out_value;
  logic        frame_start;

  int n_vec = 0;
  int n_bad = 0;

  logic [2:0] en_log [0:FRAME-1];
  logic [2:0] val_log[0:FRAME-1];
  int         fs_inside;
  logic       fs_end;

  always #5 clk = ~clk;

  charlieplex_pwm_display #(
    .PIXELCOUNT(6), .BRIGHTNESSBITS(2), .BLANKCYCLES(1), .PRESCALE(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pixel_data(pixel_data),
    .out_en(out_en), .out_value(out_value), .frame_start(frame_start)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    n_vec++;
    if (frame_start !== 1'b1) begin
      n_bad++;
      $display("FAIL %s frame_start timeout got=%b exp=1", tag, frame_start);
    end
  endtask

  // Leaves the bench in cycle 0 of the first frame.
  task automatic do_reset(input logic [11:0] d);
    pixel_data = d;
    enable = 1'b1;
    rst = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    step();
    wait_fs("do_reset");
  endtask

  // Logs cycles 0..42 of a frame; at cycle ev_c, drives new pixel_data/enable.
  task automatic run_frame(input int ev_c, input logic [11:0] ev_d, input logic ev_en);
    fs_inside = 0;
    for (int c = 0; c < FRAME; c++) begin
      en_log[c]  = out_en;
      val_log[c] = out_value;
      if (c > 0 && frame_start === 1'b1) fs_inside++;
      if (c == ev_c) begin
        pixel_data = ev_d;
        enable = ev_en;
      end
      step();
    end
    fs_end = frame_start;
  endtask

  task automatic check_frame_marks(input string tag);
    n_vec++;
    if (fs_end !== 1'b1 || fs_inside != 0) begin
      n_bad++;
      $display("FAIL %s_period got fs_end=%b inside=%0d exp fs_end=1 inside=0", tag, fs_end, fs_inside);
    end
  endtask

`ifndef CHARLIEPLEX_SKIP_DARK_EN
  task automatic test_reset;
    int n;
    rst = 1'b1;
    enable = 1'b1;
    pixel_data = 12'hFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({out_en, out_value, frame_start} !== 7'b0) begin
        n_bad++;
        $display("FAIL reset_hold%0d got en=%b val=%b fs=%b exp 0", i, out_en, out_value, frame_start);
      end
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (frame_start !== 1'b1) begin
      n_bad++;
      $display("FAIL first_fs got=%b exp=1", frame_start);
    end
    for (int k = 0; k < 2; k++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (frame_start !== 1'b1 && n < 200);
      n_vec++;
      if (n != 43) begin
        n_bad++;
        $display("FAIL fs_spacing%0d got=%0d exp=43", k, n);
      end
    end
  endtask

  task automatic test_pixel0_pwm;
    logic [2:0] e_en, e_val;
    do_reset(12'h002);
    run_frame(-1, 12'h002, 1'b1);
    for (int c = 0; c < FRAME; c++) begin
      e_en  = (c >= 2 && c <= 5) ? 3'b011 : 3'b000;
      e_val = (c >= 2 && c <= 5) ? 3'b001 : 3'b000;
      n_vec++;
      if (en_log[c] !== e_en || val_log[c] !== e_val) begin
        n_bad++;
        $display("FAIL pix0 c=%0d got en=%b val=%b exp en=%b val=%b", c, en_log[c], val_log[c], e_en, e_val);
      end
    end
    check_frame_marks("pix0");
  endtask

  task automatic test_mapping;
    logic [2:0] e_en, e_val;
    // pixel1=3, pixel3=1, pixel5=3
    do_reset(12'hC4C);
    run_frame(-1, 12'hC4C, 1'b1);
    for (int c = 0; c < FRAME; c++) begin
      if (c >= 9 && c <= 14)       begin e_en = 3'b101; e_val = 3'b001; end
      else if (c >= 23 && c <= 24) begin e_en = 3'b110; e_val = 3'b010; end
      else if (c >= 37 && c <= 42) begin e_en = 3'b110; e_val = 3'b100; end
      else                         begin e_en = 3'b000; e_val = 3'b000; end
      n_vec++;
      if (en_log[c] !== e_en || val_log[c] !== e_val) begin
        n_bad++;
        $display("FAIL map c=%0d got en=%b val=%b exp en=%b val=%b", c, en_log[c], val_log[c], e_en, e_val);
      end
    end
    check_frame_marks("map");
  endtask

  task automatic test_pixel5_dark;
    logic [2:0] e_en, e_val;
    do_reset(12'h001);
    run_frame(-1, 12'h001, 1'b1);
    for (int c = 0; c < FRAME; c++) begin
      e_en  = (c >= 2 && c <= 3) ? 3'b011 : 3'b000;
      e_val = (c >= 2 && c <= 3) ? 3'b001 : 3'b000;
      n_vec++;
      if (en_log[c] !== e_en || val_log[c] !== e_val) begin
        n_bad++;
        $display("FAIL dark5 c=%0d got en=%b val=%b exp en=%b val=%b", c, en_log[c], val_log[c], e_en, e_val);
      end
    end
  endtask

  task automatic test_tear_free;
    logic [2:0] e_en, e_val;
    do_reset(12'h002);
    run_frame(10, 12'hC00, 1'b1);
    for (int c = 0; c < FRAME; c++) begin
      e_en  = (c >= 2 && c <= 5) ? 3'b011 : 3'b000;
      e_val = (c >= 2 && c <= 5) ? 3'b001 : 3'b000;
      n_vec++;
      if (en_log[c] !== e_en || val_log[c] !== e_val) begin
        n_bad++;
        $display("FAIL tear_old c=%0d got en=%b val=%b exp en=%b val=%b", c, en_log[c], val_log[c], e_en, e_val);
      end
    end
    run_frame(-1, 12'hC00, 1'b1);
    for (int c = 0; c < FRAME; c++) begin
      e_en  = (c >= 37) ? 3'b110 : 3'b000;
      e_val = (c >= 37) ? 3'b100 : 3'b000;
      n_vec++;
      if (en_log[c] !== e_en || val_log[c] !== e_val) begin
        n_bad++;
        $display("FAIL tear_new c=%0d got en=%b val=%b exp en=%b val=%b", c, en_log[c], val_log[c], e_en, e_val);
      end
    end
  endtask

  task automatic test_enable;
    logic [2:0] e_en, e_val;
    do_reset(12'h002);
    run_frame(3, 12'h002, 1'b0);
    for (int c = 0; c < FRAME; c++) begin
      e_en  = (c >= 2 && c <= 3) ? 3'b011 : 3'b000;
      e_val = (c >= 2 && c <= 3) ? 3'b001 : 3'b000;
      n_vec++;
      if (en_log[c] !== e_en || val_log[c] !== e_val) begin
        n_bad++;
        $display("FAIL en_off c=%0d got en=%b val=%b exp en=%b val=%b", c, en_log[c], val_log[c], e_en, e_val);
      end
    end
    check_frame_marks("en_off");
    run_frame(0, 12'h002, 1'b1);
    for (int c = 0; c < FRAME; c++) begin
      e_en  = (c >= 2 && c <= 5) ? 3'b011 : 3'b000;
      n_vec++;
      if (en_log[c] !== e_en) begin
        n_bad++;
        $display("FAIL en_on c=%0d got en=%b exp en=%b", c, en_log[c], e_en);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] e_en, e_val;
    do_reset(12'h002);
    step(); step(); step();
    n_vec++;
    if (out_en !== 3'b011 || out_value !== 3'b001) begin
      n_bad++;
      $display("FAIL mid_pre got en=%b val=%b exp en=011 val=001", out_en, out_value);
    end
    rst = 1'b1;
    pixel_data = 12'h001;
    step();
    n_vec++;
    if ({out_en, out_value, frame_start} !== 7'b0) begin
      n_bad++;
      $display("FAIL mid_rst got en=%b val=%b fs=%b exp 0", out_en, out_value, frame_start);
    end
    rst = 1'b0;
    step();
    n_vec++;
    if (frame_start !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_restart_fs got=%b exp=1", frame_start);
    end
    run_frame(-1, 12'h001, 1'b1);
    for (int c = 0; c < FRAME; c++) begin
      e_en  = (c >= 2 && c <= 3) ? 3'b011 : 3'b000;
      e_val = (c >= 2 && c <= 3) ? 3'b001 : 3'b000;
      n_vec++;
      if (en_log[c] !== e_en || val_log[c] !== e_val) begin
        n_bad++;
        $display("FAIL mid_frame c=%0d got en=%b val=%b exp en=%b val=%b", c, en_log[c], val_log[c], e_en, e_val);
      end
    end
  endtask
`else
  task automatic test_skip_dark;
    logic [2:0] e_en, e_val;
    int n;
    do_reset(12'h0C0);
    for (int c = 0; c < 13; c++) begin
      e_en  = (c >= 5 && c <= 10) ? 3'b110 : 3'b000;
      e_val = (c >= 5 && c <= 10) ? 3'b010 : 3'b000;
      n_vec++;
      if (out_en !== e_en || out_value !== e_val) begin
        n_bad++;
        $display("FAIL skip c=%0d got en=%b val=%b exp en=%b val=%b", c, out_en, out_value, e_en, e_val);
      end
      step();
    end
    n_vec++;
    if (frame_start !== 1'b1) begin
      n_bad++;
      $display("FAIL skip_period13 got fs=%b exp=1", frame_start);
    end
    n = 0;
    do begin
      step();
      n++;
    end while (frame_start !== 1'b1 && n < 200);
    n_vec++;
    if (n != 13) begin
      n_bad++;
      $display("FAIL skip_spacing got=%0d exp=13", n);
    end
  endtask
`endif

  initial begin
`ifndef CHARLIEPLEX_SKIP_DARK_EN
    test_reset();
    test_pixel0_pwm();
    test_mapping();
    test_pixel5_dark();
    test_tear_free();
    test_enable();
    test_reset_mid();
`else
    test_skip_dark();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
